// File: rtl/simple_maxpool_col_unit_pkg.sv
// Shared definitions for the vertical max-pool stage.
//   IMG_WIDTH / TIME_STEPS : default geometry (spike slots per row, bits per slot)
//   ROW_W                  : width of one pooled row vector
//   mp_state_e             : layer-level control state
package simple_maxpool_col_unit_pkg;
  localparam int IMG_WIDTH  = 16;
  localparam int TIME_STEPS = 4;
  localparam int ROW_W      = IMG_WIDTH * TIME_STEPS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mp_state_e;
endpackage

// File: rtl/simple_maxpool_col_unit.sv
// Vertical stage of the 3x3 / stride-2 / pad-1 spiking max-pool.
// ORs pooled input rows 2r-1, 2r, 2r+1 into output row r (row -1 = zero pad),
// emits img_size/2 rows per channel and counts channels to layer completion.
// Ports:
//   s_clk, s_rst           clock, async active-low reset
//   code_valid             pulse: latch conv_in_ch / conv_img_size, restart layer
//   i_row_valid/i_row_data pooled row from the horizontal stage
//   o_pool_valid/o_pool_data/o_row_idx/o_ch_idx  pooled output row + position
//   o_layer_done           pulse with last row of last channel
//   o_calculating_flag     channel partially received
//   o_overrun_err          sticky: row arrived after layer completion
module simple_maxpool_col_unit
  import simple_maxpool_col_unit_pkg::*;
#(
  parameter int P_IMG_WIDTH  = IMG_WIDTH,
  parameter int P_TIME_STEPS = TIME_STEPS,
  parameter int P_ROW_W      = P_IMG_WIDTH * P_TIME_STEPS
) (
  input  logic               s_clk,
  input  logic               s_rst,
  input  logic               code_valid,
  input  logic [15:0]        conv_in_ch,
  input  logic [15:0]        conv_img_size,
  input  logic               i_row_valid,
  input  logic [P_ROW_W-1:0] i_row_data,
  output logic               o_pool_valid,
  output logic [P_ROW_W-1:0] o_pool_data,
  output logic [5:0]         o_row_idx,
  output logic [15:0]        o_ch_idx,
  output logic               o_layer_done,
  output logic               o_calculating_flag,
  output logic               o_overrun_err
);

  mp_state_e          r_state, w_state_nxt;
  logic [15:0]        r_img_size, r_in_ch, r_ch;
  logic [5:0]         r_in_row, w_in_row_nxt;
  logic [P_ROW_W-1:0] r_carry, r_acc;

  logic w_accept, w_overrun, w_emit, w_ch_end, w_layer_end;
  logic w_last_row, w_last_ch;

  assign w_last_row = ({10'd0, r_in_row} == (r_img_size - 16'd1));
  assign w_last_ch  = (r_ch == (r_in_ch - 16'd1));

  // state register
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (code_valid) w_state_nxt = ST_RUN;
      ST_RUN:  if (!code_valid && w_layer_end) w_state_nxt = ST_DONE;
      ST_DONE: if (code_valid) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // control decode; code_valid wins over a coincident row
  always_comb begin
    w_accept    = (r_state == ST_RUN)  && i_row_valid && !code_valid;
    w_overrun   = (r_state == ST_DONE) && i_row_valid && !code_valid;
    w_emit      = w_accept && r_in_row[0];
    w_ch_end    = w_emit && w_last_row;
    w_layer_end = w_ch_end && w_last_ch;
    w_in_row_nxt = r_in_row;
    if (code_valid)    w_in_row_nxt = 6'd0;
    else if (w_accept) w_in_row_nxt = w_ch_end ? 6'd0 : r_in_row + 6'd1;
  end

  // datapath
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_img_size         <= '0;
      r_in_ch            <= '0;
      r_ch               <= '0;
      r_in_row           <= '0;
      r_carry            <= '0;
      r_acc              <= '0;
      o_pool_valid       <= 1'b0;
      o_pool_data        <= '0;
      o_row_idx          <= '0;
      o_ch_idx           <= '0;
      o_layer_done       <= 1'b0;
      o_calculating_flag <= 1'b0;
      o_overrun_err      <= 1'b0;
    end else begin
      o_pool_valid       <= 1'b0;
      o_layer_done       <= 1'b0;
      r_in_row           <= w_in_row_nxt;
      o_calculating_flag <= (w_state_nxt == ST_RUN) && (w_in_row_nxt != 6'd0);
      if (code_valid) begin
        r_img_size    <= conv_img_size;
        r_in_ch       <= conv_in_ch;
        r_ch          <= '0;
        r_carry       <= '0;
        r_acc         <= '0;
        o_overrun_err <= 1'b0;
      end else begin
        if (w_overrun) o_overrun_err <= 1'b1;
        if (w_accept && !r_in_row[0]) begin
          // even row 2r opens window r; carry holds row 2r-1 (0 at channel start)
          r_acc <= r_carry | i_row_data;
        end
        if (w_emit) begin
          o_pool_valid <= 1'b1;
          o_pool_data  <= r_acc | i_row_data;
          o_row_idx    <= {1'b0, r_in_row[5:1]};
          o_ch_idx     <= r_ch;
          if (w_ch_end) begin
            // clear so nothing leaks into the next channel's top padding
            r_carry      <= '0;
            r_acc        <= '0;
            r_ch         <= r_ch + 16'd1;
            o_layer_done <= w_last_ch;
          end else begin
            r_carry <= i_row_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_maxpool_col_unit.sv
module tb_simple_maxpool_col_unit;
  localparam int ROW_W = 64;

  logic             s_clk = 1'b0;
  logic             s_rst = 1'b0;
  logic             code_valid = 1'b0;
  logic [15:0]      conv_in_ch = '0;
  logic [15:0]      conv_img_size = '0;
  logic             i_row_valid = 1'b0;
  logic [ROW_W-1:0] i_row_data = '0;
  logic             o_pool_valid;
  logic [ROW_W-1:0] o_pool_data;
  logic [5:0]       o_row_idx;
  logic [15:0]      o_ch_idx;
  logic             o_layer_done;
  logic             o_calculating_flag;
  logic             o_overrun_err;

  simple_maxpool_col_unit dut (
    .s_clk(s_clk), .s_rst(s_rst), .code_valid(code_valid),
    .conv_in_ch(conv_in_ch), .conv_img_size(conv_img_size),
    .i_row_valid(i_row_valid), .i_row_data(i_row_data),
    .o_pool_valid(o_pool_valid), .o_pool_data(o_pool_data),
    .o_row_idx(o_row_idx), .o_ch_idx(o_ch_idx), .o_layer_done(o_layer_done),
    .o_calculating_flag(o_calculating_flag), .o_overrun_err(o_overrun_err)
  );

  always #5 s_clk = ~s_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge s_clk) cyc <= cyc + 1;

  // output log captured on the falling edge
  logic [ROW_W-1:0] q_data[$];
  int q_row[$];
  int q_ch[$];
  int q_done[$];
  int q_cyc[$];

  always @(negedge s_clk) begin
    if (o_pool_valid) begin
      q_data.push_back(o_pool_data);
      q_row.push_back(int'(o_row_idx));
      q_ch.push_back(int'(o_ch_idx));
      q_done.push_back(int'(o_layer_done));
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    q_data.delete(); q_row.delete(); q_ch.delete(); q_done.delete(); q_cyc.delete();
  endtask

  task automatic do_code(input int ch, input int size);
    @(negedge s_clk);
    code_valid = 1'b1; conv_in_ch = 16'(ch); conv_img_size = 16'(size);
    @(negedge s_clk);
    code_valid = 1'b0;
  endtask

  task automatic send_row(input logic [ROW_W-1:0] d);
    @(negedge s_clk);
    i_row_valid = 1'b1; i_row_data = d;
    @(negedge s_clk);
    i_row_valid = 1'b0; i_row_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge s_clk);
  endtask

  task automatic test_reset();
    s_rst = 1'b0;
    idle(2);
    n_tests++; if (o_pool_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_pool_valid); end
    n_tests++; if (o_pool_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", o_pool_data); end
    n_tests++; if (o_row_idx !== 6'd0 || o_ch_idx !== 16'd0) begin n_fail++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", o_row_idx, o_ch_idx); end
    n_tests++; if ({o_layer_done, o_calculating_flag, o_overrun_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {o_layer_done, o_calculating_flag, o_overrun_err}); end
    s_rst = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    clear_log();
    do_code(1, 4);
    send_row(64'h1);
    n_tests++; if (o_calculating_flag !== 1'b1) begin n_fail++; $display("FAIL basic_flag_mid got=%b exp=1", o_calculating_flag); end
    send_row(64'h2);
    send_row(64'h4);
    send_row(64'h8);
    n_tests++; if (o_calculating_flag !== 1'b0) begin n_fail++; $display("FAIL basic_flag_end got=%b exp=0", o_calculating_flag); end
    idle(2);
    n_tests++; if (q_data.size() !== 2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", q_data.size()); end
    if (q_data.size() >= 2) begin
      n_tests++; if (q_data[0] !== 64'h3 || q_row[0] !== 0 || q_done[0] !== 0) begin n_fail++; $display("FAIL basic_row0 got=%h/%0d/%0d exp=3/0/0", q_data[0], q_row[0], q_done[0]); end
      n_tests++; if (q_data[1] !== 64'hE || q_row[1] !== 1 || q_done[1] !== 1) begin n_fail++; $display("FAIL basic_row1 got=%h/%0d/%0d exp=e/1/1", q_data[1], q_row[1], q_done[1]); end
    end
    n_tests++; if (o_pool_data !== 64'hE) begin n_fail++; $display("FAIL basic_hold got=%h exp=e", o_pool_data); end
  endtask

  task automatic test_overrun();
    clear_log();
    send_row(64'hF);
    idle(2);
    n_tests++; if (o_overrun_err !== 1'b1) begin n_fail++; $display("FAIL overrun_set got=%b exp=1", o_overrun_err); end
    n_tests++; if (q_data.size() !== 0) begin n_fail++; $display("FAIL overrun_no_output got=%0d exp=0", q_data.size()); end
    do_code(1, 4);
    n_tests++; if (o_overrun_err !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got=%b exp=0", o_overrun_err); end
  endtask

  task automatic test_back_to_back();
    logic [ROW_W-1:0] exp_d[4];
    int in_cyc[4];
    exp_d[0] = 64'h03; exp_d[1] = 64'h0E; exp_d[2] = 64'h38; exp_d[3] = 64'hE0;
    clear_log();
    do_code(1, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge s_clk);
      i_row_valid = 1'b1; i_row_data = 64'h1 << i;
      if (i % 2 == 1) in_cyc[i/2] = cyc;
    end
    @(negedge s_clk);
    i_row_valid = 1'b0; i_row_data = '0;
    idle(2);
    n_tests++; if (q_data.size() !== 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", q_data.size()); end
    for (int k = 0; k < 4; k++) begin
      if (q_data.size() > k) begin
        n_tests++; if (q_data[k] !== exp_d[k] || q_row[k] !== k) begin n_fail++; $display("FAIL b2b_row%0d got=%h/%0d exp=%h/%0d", k, q_data[k], q_row[k], exp_d[k], k); end
        n_tests++; if (q_cyc[k] !== in_cyc[k] + 1) begin n_fail++; $display("FAIL b2b_latency%0d got=%0d exp=%0d", k, q_cyc[k], in_cyc[k] + 1); end
      end
    end
  endtask

  task automatic test_multi_ch();
    logic [ROW_W-1:0] ones;
    int ndone;
    ones = '1;
    clear_log();
    do_code(3, 4);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++) send_row((c == 1) ? ones : '0);
    idle(2);
    n_tests++; if (q_data.size() !== 6) begin n_fail++; $display("FAIL mch_count got=%0d exp=6", q_data.size()); end
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      if (q_data.size() > k) begin
        n_tests++;
        if (q_data[k] !== ((k / 2 == 1) ? ones : '0) || q_ch[k] !== k / 2 || q_row[k] !== k % 2) begin
          n_fail++; $display("FAIL mch_out%0d got=%h/ch%0d/row%0d exp_ch=%0d exp_row=%0d", k, q_data[k], q_ch[k], q_row[k], k / 2, k % 2);
        end
        ndone += q_done[k];
      end
    end
    n_tests++; if (ndone !== 1 || (q_done.size() == 6 && q_done[5] !== 1)) begin n_fail++; $display("FAIL mch_done got=%0d exp=1 on last", ndone); end
  endtask

  task automatic test_simultaneous();
    clear_log();
    @(negedge s_clk);
    code_valid = 1'b1; conv_in_ch = 16'd1; conv_img_size = 16'd4;
    i_row_valid = 1'b1; i_row_data = 64'hF;
    @(negedge s_clk);
    code_valid = 1'b0; i_row_valid = 1'b0; i_row_data = '0;
    n_tests++; if (o_calculating_flag !== 1'b0) begin n_fail++; $display("FAIL simul_flag got=%b exp=0", o_calculating_flag); end
    send_row(64'h1); send_row(64'h2); send_row(64'h4); send_row(64'h8);
    idle(2);
    n_tests++;
    if (q_data.size() !== 2 || q_data[0] !== 64'h3 || q_data[1] !== 64'hE) begin
      n_fail++; $display("FAIL simul_drop got_n=%0d first=%h exp_n=2 first=3", q_data.size(), (q_data.size() > 0) ? q_data[0] : '0);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    do_code(1, 8);
    send_row(64'h1); send_row(64'h2); send_row(64'h4);
    #2 s_rst = 1'b0;
    #1;
    n_tests++; if ({o_pool_valid, o_layer_done, o_calculating_flag, o_overrun_err} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flags got=%b exp=0000", {o_pool_valid, o_layer_done, o_calculating_flag, o_overrun_err}); end
    n_tests++; if (o_pool_data !== '0 || o_row_idx !== 6'd0 || o_ch_idx !== 16'd0) begin n_fail++; $display("FAIL rstmid_data got=%h/%0d/%0d exp=0/0/0", o_pool_data, o_row_idx, o_ch_idx); end
    idle(1);
    s_rst = 1'b1;
    clear_log();
    send_row(64'hF);   // IDLE after reset: ignored
    do_code(1, 8);
    send_row(64'h10); send_row(64'h20);
    idle(2);
    n_tests++;
    if (q_data.size() !== 1 || q_data[0] !== 64'h30 || q_row[0] !== 0) begin
      n_fail++; $display("FAIL rstmid_restart got_n=%0d first=%h exp_n=1 first=30", q_data.size(), (q_data.size() > 0) ? q_data[0] : '0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_multi_ch();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_maxpool_col_unit.md
Name: simple_maxpool_col_unit

Overview:
- Vertical stage of the 3x3 / stride-2 / pad-1 spiking max-pool.
- Sits directly downstream of the horizontal row pooling unit and consumes its pooled-row pulses (i_row_valid / i_row_data).
- For each channel it ORs pooled rows 2r-1, 2r and 2r+1 into output row r, with row -1 treated as zero padding. It emits img_size/2 rows per channel and counts channels until the layer is complete.

Parameters:
- P_IMG_WIDTH, `IMG_WIDTH, spike slots per row.
- P_TIME_STEPS, `TIME_STEPS, time-step bits per slot.
- P_ROW_W, P_IMG_WIDTH*P_TIME_STEPS, row vector width.

Ports:
- s_clk  in  1  system clock.
- s_rst  in  1  asynchronous, active-low reset.
- code_valid  in  1  one-cycle pulse; latches layer configuration.
- conv_in_ch  in  16  channels in the layer.
- conv_img_size  in  16  input rows per channel; even, 4..64.
- i_row_valid  in  1  one-cycle pulse per horizontally pooled row.
- i_row_data  in  P_ROW_W  pooled row; slot k at [(k+1)*T-1 : k*T].
- o_pool_valid  out  1  one-cycle pulse per vertically pooled row.
- o_pool_data  out  P_ROW_W  pooled output row.
- o_row_idx  out  6  output row index within the channel, 0..img_size/2-1.
- o_ch_idx  out  16  channel index of the current output.
- o_layer_done  out  1  one-cycle pulse with the last row of the last channel.
- o_calculating_flag  out  1  high while a channel is partially received.
- o_overrun_err  out  1  sticky; a row arrived after the layer completed.

Behaviour:
- Reset values: all outputs 0; all internal registers (r_carry, r_acc, counters, configuration) 0.
- code_valid:
  - Latches r_img_size and r_in_ch.
  - Clears the row counter, channel counter, r_carry, r_acc and o_overrun_err.
  - Has priority over an i_row_valid arriving in the same cycle; that row is dropped.
- r_in_row counts 0..r_img_size-1 and advances only on i_row_valid.
- On i_row_valid with r_in_row even (row 2r):
  - r_acc <= r_carry | i_row_data.
  - r_carry is 0 at channel start, giving the top padding.
- On i_row_valid with r_in_row odd (row 2r+1):
  - Registered next cycle: o_pool_data <= r_acc | i_row_data; o_pool_valid = 1; o_row_idx = r_in_row>>1.
  - r_carry <= i_row_data, which becomes row 2r+1 for window r+1.
- Latency: exactly 1 cycle from the odd input row to o_pool_valid.
- o_pool_data holds its value between pulses.
- End of channel (odd row with r_in_row == r_img_size-1):
  - r_in_row <= 0; r_carry <= 0; r_acc <= 0.
  - o_ch_idx for the emitted row is the old channel index; the channel counter increments after.
  - If this is the last channel (ch == r_in_ch-1): o_layer_done pulses together with o_pool_valid, and the state moves to DONE.
- State machine:
  - IDLE -> RUN on code_valid.
  - RUN -> DONE on the last row of the last channel.
  - DONE -> RUN on code_valid.
  - In IDLE, rows are ignored.
  - In DONE, any i_row_valid sets o_overrun_err and is discarded.
- o_calculating_flag:
  - Registered; 1 when in RUN and r_in_row != 0 after the update.
  - Falls in the same cycle as the last o_pool_valid of the channel.
- Back-to-back i_row_valid on consecutive cycles is fully supported; the block has no backpressure.
- Upper row slots (>= img_size/2) are passed through ORed; upstream guarantees they are zero.
- Asynchronous reset mid-channel: everything returns to reset values immediately; the next code_valid restarts cleanly.

Decomposition:
- Shared package/header: maxpool state encodings (IDLE/RUN/DONE) and the row-width localparam. `IMG_WIDTH and `TIME_STEPS come from hyper_para.
- No sub-module is needed. Optionally, a generate loop of per-slot OR registers may be used.

Test Plan:
- Basic pooling:
  - Stimulus: code(ch=1, size=4); rows R0=0x1, R1=0x2, R2=0x4, R3=0x8 in slot 0 (T=4).
  - Required: out row0 = 0x3 (pad|R0|R1), row1 = 0xE (R1|R2|R3); o_row_idx 0, 1; o_layer_done with row1.
- Latency and back-to-back:
  - Stimulus: rows every cycle, size=8.
  - Required: o_pool_valid exactly 1 cycle after each odd row; 4 pulses; no gaps lost.
- Multi-channel:
  - Stimulus: ch=3, size=4, all-ones rows in channel 1 only.
  - Required: channel 0 and 2 outputs are 0 (no carry leakage across channels); o_ch_idx = 0, 0, 1, 1, 2, 2; a single o_layer_done.
- Overrun:
  - Stimulus: after o_layer_done, inject one row.
  - Required: o_overrun_err = 1 and no o_pool_valid. Then code_valid clears the error.
- Simultaneous events:
  - Stimulus: code_valid and i_row_valid in the same cycle.
  - Required: the row is dropped; r_in_row = 0 afterwards.
- Reset mid-operation:
  - Stimulus: assert s_rst low after 3 rows of size=8.
  - Required: all outputs 0 and o_calculating_flag = 0. After re-code, the first output equals rows 0|1 of the new stream.
